// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: funct3 encodings, FSM states
// and the access-size byte mask helper.
package mem_pkg;

    localparam logic [2:0] F3Lb  = 3'b000;
    localparam logic [2:0] F3Lh  = 3'b001;
    localparam logic [2:0] F3Lw  = 3'b010;
    localparam logic [2:0] F3Ld  = 3'b011;
    localparam logic [2:0] F3Lbu = 3'b100;
    localparam logic [2:0] F3Lhu = 3'b101;
    localparam logic [2:0] F3Lwu = 3'b110;

    localparam logic [2:0] F3Sb  = 3'b000;
    localparam logic [2:0] F3Sh  = 3'b001;
    localparam logic [2:0] F3Sw  = 3'b010;
    localparam logic [2:0] F3Sd  = 3'b011;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait
    } mem_state_e;

    // Unaligned byte mask for the access size; reserved encodings map to 8 bytes.
    function automatic logic [7:0] size_mask(input logic [2:0] funct3, input logic is_store);
        logic [7:0] mask;
        if (is_store) begin
            case (funct3)
                F3Sb:    mask = 8'h01;
                F3Sh:    mask = 8'h03;
                F3Sw:    mask = 8'h0f;
                F3Sd:    mask = 8'hff;
                default: mask = 8'hff;
            endcase
        end else begin
            case (funct3)
                F3Lb, F3Lbu: mask = 8'h01;
                F3Lh, F3Lhu: mask = 8'h03;
                F3Lw, F3Lwu: mask = 8'h0f;
                default:     mask = 8'hff;
            endcase
        end
        return mask;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Aligns a 64-bit read word to the access offset and sign/zero-extends it
// according to the load funct3.
module load_extend
    import mem_pkg::*;
(
    input  logic [63:0] rdata,
    input  logic [2:0]  offset,
    input  logic [2:0]  funct3,
    output logic [63:0] value
);

    logic [63:0] shifted;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        case (funct3)
            F3Lb:    value = {{56{shifted[7]}}, shifted[7:0]};
            F3Lh:    value = {{48{shifted[15]}}, shifted[15:0]};
            F3Lw:    value = {{32{shifted[31]}}, shifted[31:0]};
            F3Lbu:   value = {56'b0, shifted[7:0]};
            F3Lhu:   value = {48'b0, shifted[15:0]};
            F3Lwu:   value = {32'b0, shifted[31:0]};
            F3Ld:    value = shifted;
            default: value = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: issues data-memory requests, waits for load responses and
// stalls upstream. Optional macro MEM_MISALIGN_TRAP_EN adds a misaligned-access trap.
module mem_access
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [63:0] alu_result,
    input  logic [63:0] store_data,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic        memread,
    input  logic        memwrite,
    input  logic        memtoreg,
    input  logic        regwrite,
    output logic        dmem_req_valid,
    output logic [63:0] dmem_addr,
    output logic        dmem_we,
    output logic [7:0]  dmem_wstrb,
    output logic [63:0] dmem_wdata,
    input  logic        dmem_req_ready,
    input  logic        dmem_rsp_valid,
    input  logic [63:0] dmem_rdata,
    output logic [63:0] read_data_out,
    output logic [63:0] result_alu_out,
    output logic [4:0]  rd_out,
    output logic        memtoreg_out,
    output logic        regwrite_out,
    output logic        wb_valid,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic        misalign_exc,
`endif
    output logic        stall
);

    mem_state_e  state_q, state_d;
    logic        is_mem, is_store, trap_hit;
    logic        req, done, hold, trap;
    logic [2:0]  offset;
    logic [7:0]  mask;
    logic [63:0] load_value;

    assign is_store = memwrite;
    assign is_mem   = memread | memwrite;
    assign offset   = alu_result[2:0];
    assign mask     = size_mask(funct3, is_store);

`ifdef MEM_MISALIGN_TRAP_EN
    // {mask[7],mask[3],mask[1]} equals size-1, the offset bits that must be zero.
    assign trap_hit     = (offset & {mask[7], mask[3], mask[1]}) != 3'b000;
    assign misalign_exc = reset & trap;
`else
    assign trap_hit = 1'b0;
`endif

    load_extend u_load_extend (
        .rdata  (dmem_rdata),
        .offset (offset),
        .funct3 (funct3),
        .value  (load_value)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req     = 1'b0;
        done    = 1'b0;
        hold    = 1'b0;
        trap    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ex_valid) begin
                    if (!is_mem) begin
                        done = 1'b1;
                    end else if (trap_hit) begin
                        trap = 1'b1;
                        done = 1'b1;
                    end else begin
                        req = 1'b1;
                        if (dmem_req_ready && is_store) begin
                            done = 1'b1;
                        end else begin
                            hold    = 1'b1;
                            state_d = dmem_req_ready ? StWait : StReq;
                        end
                    end
                end
            end
            StReq: begin
                req = 1'b1;
                if (dmem_req_ready && is_store) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end else begin
                    hold = 1'b1;
                    if (dmem_req_ready) state_d = StWait;
                end
            end
            StWait: begin
                // Responses are only meaningful here; elsewhere they are ignored.
                if (dmem_rsp_valid) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end else begin
                    hold = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign dmem_req_valid = reset & req;
    assign dmem_addr      = reset ? {alu_result[63:3], 3'b000} : 64'b0;
    assign dmem_we        = reset & is_store;
    assign dmem_wstrb     = (reset && is_store) ? 8'(mask << offset) : 8'h00;
    assign dmem_wdata     = reset ? (store_data << {offset, 3'b000}) : 64'b0;
    assign read_data_out  = reset ? load_value : 64'b0;
    assign result_alu_out = reset ? alu_result : 64'b0;
    assign rd_out         = reset ? rd : 5'b0;
    assign memtoreg_out   = reset & memtoreg;
    assign wb_valid       = reset & done;
    assign stall          = reset & hold;
    assign regwrite_out   = reset & regwrite & done & ~trap;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios plus randomized memory ops
// checked against a byte-level reference model.
`timescale 1ns/1ps
module tb_mem_access;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid, memread, memwrite, memtoreg, regwrite;
    logic [63:0] alu_result, store_data, dmem_rdata;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        dmem_req_valid, dmem_we, dmem_req_ready, dmem_rsp_valid;
    logic [63:0] dmem_addr, dmem_wdata, read_data_out, result_alu_out;
    logic [7:0]  dmem_wstrb;
    logic [4:0]  rd_out;
    logic        memtoreg_out, regwrite_out, wb_valid, stall;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign_exc;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mem_access dut (
        .clk            (clk),
        .reset          (reset),
        .ex_valid       (ex_valid),
        .alu_result     (alu_result),
        .store_data     (store_data),
        .funct3         (funct3),
        .rd             (rd),
        .memread        (memread),
        .memwrite       (memwrite),
        .memtoreg       (memtoreg),
        .regwrite       (regwrite),
        .dmem_req_valid (dmem_req_valid),
        .dmem_addr      (dmem_addr),
        .dmem_we        (dmem_we),
        .dmem_wstrb     (dmem_wstrb),
        .dmem_wdata     (dmem_wdata),
        .dmem_req_ready (dmem_req_ready),
        .dmem_rsp_valid (dmem_rsp_valid),
        .dmem_rdata     (dmem_rdata),
        .read_data_out  (read_data_out),
        .result_alu_out (result_alu_out),
        .rd_out         (rd_out),
        .memtoreg_out   (memtoreg_out),
        .regwrite_out   (regwrite_out),
        .wb_valid       (wb_valid),
`ifdef MEM_MISALIGN_TRAP_EN
        .misalign_exc   (misalign_exc),
`endif
        .stall          (stall)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got running want finished");
        $fatal(1);
    end

    // Access size in bytes as the ISA defines it (reserved encodings are 8 bytes).
    function automatic int op_size(input bit ld, input logic [2:0] f3);
        int s;
        if (ld) begin
            case (f3 % 4)
                0: s = 1;
                1: s = 2;
                2: s = 4;
                default: s = 8;
            endcase
        end else begin
            s = (f3 > 3) ? 8 : (1 << f3);
        end
        return s;
    endfunction

    function automatic logic [63:0] model_load(input logic [63:0] rdat, input int off,
                                               input int size, input bit sgn);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < size; i++) begin
            if (off + i < 8) v[8*i +: 8] = rdat[8*(off+i) +: 8];
        end
        if (sgn && v[8*size-1]) begin
            for (int b = 8 * size; b < 64; b++) v[b] = 1'b1;
        end
        return v;
    endfunction

    task automatic set_idle();
        ex_valid       = 1'b0;
        memread        = 1'b0;
        memwrite       = 1'b0;
        memtoreg       = 1'b0;
        regwrite       = 1'b0;
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
    endtask

    // Drives one memory op: k cycles of req_ready low, then for loads m idle WAIT cycles.
    task automatic test_mem_op(input bit ld, input logic [2:0] f3, input logic [63:0] addr,
                               input logic [63:0] sdata, input logic [63:0] rdat,
                               input int k, input int m, input bit noise, input string name);
        int          size, off, ncyc;
        bit          sgn, mis, rw, exp_req, done;
        logic [7:0]  exp_strb;
        logic [63:0] exp_wdata, exp_load, exp_addr;
        logic [4:0]  rdv;
        size = op_size(ld, f3);
        off  = int'(addr[2:0]);
        sgn  = ld && (f3 < 3);
        mis  = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        mis  = (off % size) != 0;
`endif
        exp_addr  = addr & ~64'h7;
        exp_strb  = '0;
        exp_wdata = '0;
        for (int lane = 0; lane < 8; lane++) begin
            if (lane >= off) begin
                exp_wdata[8*lane +: 8] = sdata[8*(lane-off) +: 8];
                if (lane < off + size) exp_strb[lane] = 1'b1;
            end
        end
        exp_load = model_load(rdat, off, size, sgn);
        ncyc     = mis ? 1 : (ld ? k + m + 2 : k + 1);
        rw       = ld ? 1'b1 : 1'(($urandom % 2));
        rdv      = 5'($urandom);

        @(negedge clk);
        ex_valid   = 1'b1;
        alu_result = addr;
        store_data = sdata;
        funct3     = f3;
        rd         = rdv;
        memread    = ld;
        memwrite   = !ld;
        memtoreg   = ld;
        regwrite   = rw;
        for (int c = 0; c < ncyc; c++) begin
            if (c > 0) @(negedge clk);
            if (c <= k) begin
                dmem_req_ready = (c >= k);
                dmem_rsp_valid = noise ? 1'(($urandom % 2)) : 1'b0;
                dmem_rdata     = {$urandom, $urandom};
            end else begin
                dmem_req_ready = 1'(($urandom % 2));
                dmem_rsp_valid = (c == k + 1 + m);
                dmem_rdata     = (c == k + 1 + m) ? rdat : {$urandom, $urandom};
            end
            #1;
            done    = (c == ncyc - 1);
            exp_req = !mis && (c <= k);
            total++;
            if (dmem_req_valid !== exp_req) begin
                bad++;
                $display("FAIL %s req_valid c%0d: got %b want %b", name, c, dmem_req_valid, exp_req);
            end
            total++;
            if (stall !== !done) begin
                bad++;
                $display("FAIL %s stall c%0d: got %b want %b", name, c, stall, !done);
            end
            total++;
            if (wb_valid !== done) begin
                bad++;
                $display("FAIL %s wb_valid c%0d: got %b want %b", name, c, wb_valid, done);
            end
            total++;
            if (regwrite_out !== (done && rw && !mis)) begin
                bad++;
                $display("FAIL %s regwrite_out c%0d: got %b want %b", name, c, regwrite_out,
                         done && rw && !mis);
            end
`ifdef MEM_MISALIGN_TRAP_EN
            total++;
            if (misalign_exc !== (mis && c == 0)) begin
                bad++;
                $display("FAIL %s misalign_exc c%0d: got %b want %b", name, c, misalign_exc,
                         mis && c == 0);
            end
`endif
            if (exp_req) begin
                total++;
                if (dmem_addr !== exp_addr || dmem_we !== !ld) begin
                    bad++;
                    $display("FAIL %s addr/we c%0d: got %h/%b want %h/%b", name, c, dmem_addr,
                             dmem_we, exp_addr, !ld);
                end
                if (!ld) begin
                    total++;
                    if (dmem_wstrb !== exp_strb || dmem_wdata !== exp_wdata) begin
                        bad++;
                        $display("FAIL %s wstrb/wdata c%0d: got %h/%h want %h/%h", name, c,
                                 dmem_wstrb, dmem_wdata, exp_strb, exp_wdata);
                    end
                end
            end
            if (c == 0) begin
                total++;
                if (rd_out !== rdv || memtoreg_out !== ld || result_alu_out !== addr) begin
                    bad++;
                    $display("FAIL %s passthru: got rd=%0d mtr=%b alu=%h want rd=%0d mtr=%b alu=%h",
                             name, rd_out, memtoreg_out, result_alu_out, rdv, ld, addr);
                end
            end
            if (done && ld && !mis) begin
                total++;
                if (read_data_out !== exp_load) begin
                    bad++;
                    $display("FAIL %s read_data_out: got %h want %h", name, read_data_out, exp_load);
                end
            end
        end
        @(negedge clk);
        set_idle();
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset          = 1'b0;
        ex_valid       = 1'b1;
        memwrite       = 1'b1;
        memtoreg       = 1'b1;
        regwrite       = 1'b1;
        dmem_req_ready = 1'b1;
        alu_result     = 64'h1234_5678_9abc_def5;
        store_data     = 64'hdead_beef_cafe_f00d;
        rd             = 5'd17;
        dmem_rdata     = 64'hffff_ffff_ffff_ffff;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            total++;
            if ({dmem_req_valid, wb_valid, stall, regwrite_out, memtoreg_out} !== 5'b0) begin
                bad++;
                $display("FAIL reset_ctrl: got %b want 00000",
                         {dmem_req_valid, wb_valid, stall, regwrite_out, memtoreg_out});
            end
            total++;
            if ((dmem_addr | dmem_wdata | read_data_out | result_alu_out) !== 64'b0 ||
                dmem_wstrb !== 8'b0 || rd_out !== 5'b0) begin
                bad++;
                $display("FAIL reset_data: got addr=%h wdata=%h rdo=%h alu=%h strb=%h rd=%0d want 0",
                         dmem_addr, dmem_wdata, read_data_out, result_alu_out, dmem_wstrb, rd_out);
            end
        end
        set_idle();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_alu_op();
        for (int i = 0; i < 4; i++) begin
            logic [63:0] v;
            v = (i == 0) ? 64'h10 : {$urandom, $urandom};
            @(negedge clk);
            ex_valid   = 1'b1;
            memread    = 1'b0;
            memwrite   = 1'b0;
            memtoreg   = 1'b0;
            regwrite   = 1'b1;
            alu_result = v;
            #1;
            total++;
            if (wb_valid !== 1'b1 || stall !== 1'b0 || dmem_req_valid !== 1'b0) begin
                bad++;
                $display("FAIL alu_op ctrl: got wb=%b stall=%b req=%b want 1/0/0",
                         wb_valid, stall, dmem_req_valid);
            end
            total++;
            if (result_alu_out !== v || regwrite_out !== 1'b1) begin
                bad++;
                $display("FAIL alu_op result: got %h rw=%b want %h rw=1", result_alu_out,
                         regwrite_out, v);
            end
        end
        @(negedge clk);
        set_idle();
    endtask

    task automatic test_reset_in_wait();
        @(negedge clk);
        ex_valid       = 1'b1;
        memread        = 1'b1;
        memtoreg       = 1'b1;
        regwrite       = 1'b1;
        funct3         = 3'b011;
        alu_result     = 64'h5000;
        dmem_req_ready = 1'b1;
        @(negedge clk);
        dmem_req_ready = 1'b0;
        #1;
        total++;
        if (stall !== 1'b1 || dmem_req_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_wait pre: got stall=%b req=%b want 1/0", stall, dmem_req_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        set_idle();
        @(negedge clk);
        reset          = 1'b1;
        dmem_rsp_valid = 1'b1;
        dmem_rdata     = 64'h0bad_0bad_0bad_0bad;
        for (int c = 0; c < 2; c++) begin
            #1;
            total++;
            if (wb_valid !== 1'b0 || stall !== 1'b0 || dmem_req_valid !== 1'b0) begin
                bad++;
                $display("FAIL rst_wait stale c%0d: got wb=%b stall=%b req=%b want 0/0/0",
                         c, wb_valid, stall, dmem_req_valid);
            end
            @(negedge clk);
        end
        set_idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            test_mem_op(1'($urandom % 2), 3'($urandom), {$urandom, $urandom},
                        {$urandom, $urandom}, {$urandom, $urandom},
                        int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b1, "random");
        end
    endtask

    initial begin
        reset      = 1'b1;
        alu_result = '0;
        store_data = '0;
        funct3     = '0;
        rd         = '0;
        dmem_rdata = '0;
        set_idle();
        test_reset();
        test_alu_op();
        test_mem_op(1'b0, 3'b000, 64'h1003, 64'hab, 64'h0, 0, 0, 1'b0, "store_sb");
        test_mem_op(1'b1, 3'b001, 64'h2006, 64'h0, 64'h8001_0000_0000_0000, 0, 3, 1'b0,
                    "load_lh");
        test_mem_op(1'b1, 3'b011, 64'h4000_0008, 64'h0, 64'h0123_4567_89ab_cdef, 2, 1, 1'b1,
                    "ld_req_stall");
        test_mem_op(1'b1, 3'b010, 64'h3002, 64'h0, 64'h8877_6655_4433_2211, 0, 0, 1'b0,
                    "lw_misaligned");
        test_mem_op(1'b0, 3'b011, 64'h6005, 64'h0102_0304_0506_0708, 64'h0, 1, 0, 1'b1,
                    "sd_misaligned");
        test_mem_op(1'b1, 3'b100, 64'h7007, 64'h0, 64'h80ff_0000_0000_0000, 0, 0, 1'b0, "lbu_top");
        test_reset_in_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; reset  in  1  synchronous active-low reset.
REQ-002 SHALL have EX/MEM-side inputs: ex_valid in 1; alu_result in 64 (address or ALU value); store_data in 64; funct3 in 3; rd in 5; memread in 1; memwrite in 1; memtoreg in 1; regwrite in 1.
REQ-003 SHALL have data-memory outputs: dmem_req_valid 1; dmem_addr 64 (bits[2:0]=0); dmem_we 1; dmem_wstrb 8; dmem_wdata 64.
REQ-004 SHALL have data-memory inputs: dmem_req_ready 1; dmem_rsp_valid 1; dmem_rdata 64.
REQ-005 SHALL have MEM/WB-side outputs: read_data_out 64; result_alu_out 64; rd_out 5; memtoreg_out 1; regwrite_out 1; wb_valid 1; stall 1 (holds EX/MEM and earlier stages).

Function
REQ-006 SHALL use FSM states IDLE, REQ, WAIT.
REQ-007 Non-memory op (ex_valid, !memread, !memwrite): wb_valid=1 same cycle, stall=0, no dmem request, state stays IDLE.
REQ-008 Memory op in IDLE: dmem_req_valid=1 same cycle; handshake on req_valid&&req_ready.
REQ-009 Request not accepted: IDLE->REQ; req_valid, addr, we, wstrb, wdata held stable until accepted.
REQ-010 Store: complete on request handshake (posted); wb_valid=1, stall=0 that cycle; state returns to IDLE.
REQ-011 Load: after handshake go to WAIT; complete on the cycle dmem_rsp_valid=1 in WAIT, then wb_valid=1, stall=0, state->IDLE.
REQ-012 stall=1 every cycle a memory op is valid and not completing that cycle.
REQ-013 Minimum load latency: 2 cycles (request accepted cycle N, response accepted N+1 earliest); store minimum 1 cycle.
REQ-014 dmem_addr = {alu_result[63:3],3'b000}; offset = alu_result[2:0].
REQ-015 Store size from funct3: SB 1, SH 2, SW 4, SD 8 bytes; wstrb = size mask << offset; wdata = store_data << (8*offset).
REQ-016 Load: rdata >> (8*offset), then LB/LH/LW sign-extend, LBU/LHU/LWU zero-extend, LD unchanged, into read_data_out.
REQ-017 result_alu_out=alu_result, rd_out=rd, memtoreg_out=memtoreg, regwrite_out=regwrite&&wb_valid, all combinational.
REQ-018 dmem_rsp_valid outside WAIT SHALL be ignored.
REQ-019 Reserved funct3 (3'b111 load, any >3'b011 store) SHALL be treated as LD/SD.

Reset
REQ-020 reset=0 at a clk edge: state->IDLE; any outstanding response discarded.
REQ-021 While reset=0: dmem_req_valid, wb_valid, stall, regwrite_out, memtoreg_out =0; data outputs 0.
REQ-022 Reset mid-WAIT: subsequent stale dmem_rsp_valid ignored per REQ-018.

Configuration
REQ-023 Macro MEM_MISALIGN_TRAP_EN defined: access with offset not a multiple of size SHALL issue no request, pulse output misalign_exc for one cycle, force regwrite_out=0, wb_valid=1, stall=0.
REQ-024 Macro absent: misalign_exc port absent; misaligned access issued per REQ-015/016, lanes beyond byte 7 dropped.

Structure
REQ-025 Package mem_pkg SHALL hold funct3 encodings (LB..LWU, SB..SD), state enum, size-mask function.
REQ-026 Sub-module load_extend SHALL implement REQ-016 (inputs rdata, offset, funct3; output 64-bit value).

Verification
REQ-027 ADD op, alu_result=0x10 -> wb_valid=1 same cycle, stall=0, no dmem_req_valid.
REQ-028 SB store_data=0xAB addr=0x1003, ready=1 -> dmem_addr=0x1000, wstrb=0x08, wdata[31:24]=0xAB, 1 cycle.
REQ-029 LH addr=0x2006, rdata=0x8001_0000_0000_0000 after 3 WAIT cycles -> read_data_out=0xFFFF_FFFF_FFFF_8001, stall for 4 cycles.
REQ-030 LD with req_ready low 2 cycles -> req fields stable in REQ, state REQ->WAIT on accept.
REQ-031 reset=0 in WAIT, then rsp_valid=1 -> no wb_valid, state IDLE.
REQ-032 With MEM_MISALIGN_TRAP_EN, LW addr=0x3002 -> misalign_exc 1 cycle, no request, regwrite_out=0.
